key_scan_ctrl: RTL

Scheduler for the front-panel push-buttons: one prescaler and a round-robin slot pointer time-share the debounce integration among four active-low keys, updating one key per sample tick. Debounced press events drive a small mode/run register bank used by the display and counter blocks. It replaces per-key free-running debounce counters and clock-gated toggles with a single-clock, fully synchronous controller.

---
 rtl/key_scan_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/key_scan_ctrl.sv
// rtl/key_scan_ctrl.sv - time-shared four-key debouncer driving a mode/run register bank
// Optional auto-repeat on keys 0 and 1 is enabled by defining KEY_REPEAT_EN.
module key_scan_ctrl #(
    parameter int TICK_DIV     = 50_000,
    parameter int DEB_MAX      = 5,
    parameter int REPEAT_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    output logic [3:0] pressed,
    output logic       key_evt,
    output logic [1:0] key_id,
    output logic [1:0] mode,
    output logic       run
);

    localparam int              PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [3:0]      DEB_TOP  = 4'(DEB_MAX);

    if (TICK_DIV < 2 || DEB_MAX < 1 || DEB_MAX > 15 ||
        REPEAT_TICKS < 1 || REPEAT_TICKS > 255) begin : g_bad_cfg
        $error("key_scan_ctrl: parameter out of range");
    end

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       act;
    logic [PRE_W-1:0] pre;
    logic             tick;
    logic [1:0]       slot;
    logic [3:0]       cnt [4];

    logic [3:0]       cur_cnt;
    logic             cur_act;
    logic             cur_pressed;
    logic [3:0]       nxt_cnt;
    logic             nxt_pressed;
    logic             press_evt;
    logic             fire;
    logic [1:0]       mode_nxt;
    logic             run_nxt;

    assign act  = ~sync2;
    assign tick = (pre == PRE_LAST);

    // Integrator update for the single key serviced on this tick.
    always_comb begin
        cur_cnt     = cnt[slot];
        cur_act     = act[slot];
        cur_pressed = pressed[slot];
        nxt_cnt     = cur_cnt;
        if (cur_act) begin
            if (cur_cnt < DEB_TOP) begin
                nxt_cnt = cur_cnt + 4'd1;
            end else begin
                nxt_cnt = DEB_TOP;
            end
        end else if (cur_cnt != 4'd0) begin
            nxt_cnt = cur_cnt - 4'd1;
        end
        nxt_pressed = cur_pressed;
        if (nxt_cnt == DEB_TOP) begin
            nxt_pressed = 1'b1;
        end else if (nxt_cnt == 4'd0) begin
            nxt_pressed = 1'b0;
        end
        press_evt = tick && nxt_pressed && !cur_pressed;
    end

`ifdef KEY_REPEAT_EN
    localparam logic [7:0] REP_TOP = 8'(REPEAT_TICKS);

    logic [7:0] rep [2];
    logic [7:0] rep_inc;
    logic       rep_visit;
    logic       rep_held;
    logic       rep_hit;

    always_comb begin
        rep_visit = tick && !slot[1];
        rep_held  = cur_pressed && nxt_pressed;
        rep_inc   = rep[slot[0]] + 8'd1;
        rep_hit   = rep_visit && rep_held && (rep_inc == REP_TOP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep[0] <= '0;
            rep[1] <= '0;
        end else if (rep_visit) begin
            if (!rep_held || rep_hit) begin
                rep[slot[0]] <= '0;
            end else begin
                rep[slot[0]] <= rep_inc;
            end
        end
    end

    assign fire = press_evt | rep_hit;
`else
    assign fire = press_evt;
`endif

    always_comb begin
        mode_nxt = mode;
        run_nxt  = run;
        if (fire) begin
            case (slot)
                2'd0:    mode_nxt = mode + 2'd1;
                2'd1:    mode_nxt = mode - 2'd1;
                2'd2:    mode_nxt = 2'd0;
                default: run_nxt  = ~run;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            pre     <= '0;
            slot    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            pressed <= '0;
            key_evt <= 1'b0;
            key_id  <= '0;
            mode    <= '0;
            run     <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            pre     <= tick ? '0 : pre + 1'b1;
            key_evt <= fire;
            mode    <= mode_nxt;
            run     <= run_nxt;
            if (tick) begin
                cnt[slot]     <= nxt_cnt;
                pressed[slot] <= nxt_pressed;
                slot          <= slot + 2'd1;
            end
            if (fire) begin
                key_id <= slot;
            end
        end
    end

endmodule
